// File: rtl/adder_pkg.sv
// Shared constants and types for the N-bit adder slice.
// The flags struct is only registered when ADDER_NBIT_OVF_EN is defined.
package adder_pkg;

  localparam int ADDER_DEFAULT_N = 32;

  typedef struct packed {
    logic c_out;
    logic ovf;
  } adder_flags_t;

endpackage

// File: rtl/adder_nbit_full_adder.sv
// Purely combinational 1-bit full adder cell.
// It is chained N times to form the ripple-carry datapath of adder_nbit.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic halfSum;

  assign halfSum = a ^ b;
  assign s       = halfSum ^ c_in;
  assign c_out   = (a & b) | (c_in & halfSum);

endmodule

// File: rtl/adder_nbit.sv
// Registered N-bit ripple-carry adder with carry-in and carry-out.
// Optional signed-overflow output is enabled with macro ADDER_NBIT_OVF_EN.
module adder_nbit
  import adder_pkg::*;
#(
  parameter int N = ADDER_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
`ifdef ADDER_NBIT_OVF_EN
  output logic         ovf,
`endif
  output logic         c_out
);

  logic [N:0]   carry;
  logic [N-1:0] sum_d;
  logic [N-1:0] sum_q;

  assign carry[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .s     (sum_d[i]),
      .c_out (carry[i+1])
    );
  end

`ifdef ADDER_NBIT_OVF_EN
  adder_flags_t flags_d;
  adder_flags_t flags_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign flags_d.c_out = carry[N];
  assign flags_d.ovf   = carry[N] ^ carry[N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      sum_q   <= sum_d;
      flags_q <= flags_d;
    end
  end

  assign c_out = flags_q.c_out;
  assign ovf   = flags_q.ovf;
`else
  logic c_out_d;
  logic c_out_q;

  assign c_out_d = carry[N];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign c_out = c_out_q;
`endif

  assign sum = sum_q;

endmodule

// File: tb/tb_adder_nbit.sv
// Self-checking bench for adder_nbit (N=32): directed corner cases, then
// random operands against an arithmetic reference model, with a reset pulse mid-run.
module tb_adder_nbit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef ADDER_NBIT_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  adder_nbit #(.N(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
`ifdef ADDER_NBIT_OVF_EN
    .ovf   (ovf),
`endif
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 33-bit unsigned addition.
  function automatic logic [W:0] modelAdd(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

`ifdef ADDER_NBIT_OVF_EN
  // Reference: signed result falls outside the 32-bit two's complement range.
  function automatic logic modelOvf(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic ci);
    longint s;
    s = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction
`endif

  // Drive inputs away from the edge, clock them in, then settle before sampling.
  task automatic applyStimulus(input logic rstV, input logic [W-1:0] aV,
                               input logic [W-1:0] bV, input logic cV);
    @(negedge clk);
    rst  = rstV;
    a    = aV;
    b    = bV;
    c_in = cV;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] expSum, input logic expCout);
    checks++;
    assert (sum === expSum) else begin
      errors++;
      $error("[TB] FAIL %s sum: got %h want %h", tag, sum, expSum);
    end
    checks++;
    assert (c_out === expCout) else begin
      errors++;
      $error("[TB] FAIL %s c_out: got %b want %b", tag, c_out, expCout);
    end
  endtask

`ifdef ADDER_NBIT_OVF_EN
  task automatic checkOvf(input string tag, input logic expOvf);
    checks++;
    assert (ovf === expOvf) else begin
      errors++;
      $error("[TB] FAIL %s ovf: got %b want %b", tag, ovf, expOvf);
    end
  endtask
`endif

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   exp;

    rst  = 1'b1;
    a    = '0;
    b    = '0;
    c_in = 1'b0;

    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    checkOutput("reset", 32'h0000_0000, 1'b0);
`ifdef ADDER_NBIT_OVF_EN
    checkOvf("reset", 1'b0);
`endif

    applyStimulus(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    checkOutput("zero", 32'h0000_0000, 1'b0);

    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    checkOutput("wrap", 32'h0000_0000, 1'b1);
`ifdef ADDER_NBIT_OVF_EN
    checkOvf("wrap", 1'b0);
`endif

    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    checkOutput("max", 32'hFFFF_FFFF, 1'b1);

    applyStimulus(1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    checkOutput("posovf", 32'h8000_0000, 1'b0);
`ifdef ADDER_NBIT_OVF_EN
    checkOvf("posovf", 1'b1);
`endif

    applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    checkOutput("negovf", 32'h0000_0000, 1'b1);
`ifdef ADDER_NBIT_OVF_EN
    checkOvf("negovf", 1'b1);
`endif

    applyStimulus(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
    checkOutput("mixed", 32'h2143_6588, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (i == 5000) begin
        applyStimulus(1'b1, ra, rb, rc);
        checkOutput("midreset", 32'h0000_0000, 1'b0);
`ifdef ADDER_NBIT_OVF_EN
        checkOvf("midreset", 1'b0);
`endif
      end else begin
        applyStimulus(1'b0, ra, rb, rc);
        exp = modelAdd(ra, rb, rc);
        checkOutput("random", exp[W-1:0], exp[W]);
`ifdef ADDER_NBIT_OVF_EN
        checkOvf("random", modelOvf(ra, rb, rc));
`endif
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
